// File: rtl/ni_rx_depacketizer_if.sv
// Flit ingress and payload egress signals of the NI receive depacketizer.
interface ni_rx_depacketizer_if;
   logic [33:0] flit_in;
   logic        flit_valid;
   logic        flit_ready;
   logic [31:0] NI_out;
   logic [3:0]  NI_out_src;
   logic        NI_out_last;
   logic        NI_out_valid;
   logic        NI_out_ready;
   logic        pkt_err;
   logic [7:0]  drop_cnt;

   // valid/ready: a transfer happens on every rising edge where both are high;
   // a source keeps its payload stable while valid is high and ready is low.
   modport master (
      output flit_in, flit_valid, NI_out_ready,
      input  flit_ready, NI_out, NI_out_src, NI_out_last, NI_out_valid, pkt_err, drop_cnt
   );
   modport slave (
      input  flit_in, flit_valid, NI_out_ready,
      output flit_ready, NI_out, NI_out_src, NI_out_last, NI_out_valid, pkt_err, drop_cnt
   );
endinterface

// File: rtl/ni_rx_depacketizer.sv
// NI receive side: validates head flits, reassembles payload words into a small
// output FIFO and drops misrouted or malformed packets.
module ni_rx_depacketizer #(
   parameter logic [3:0] NODE_ID    = 4'd0,
   parameter int         FIFO_DEPTH = 4,
   parameter int         MAX_LEN    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   ni_rx_depacketizer_if.slave  bus,
   output logic [1:0]           o_dbg_state
);
   localparam int         AW     = $clog2(FIFO_DEPTH);
   localparam logic [1:0] T_HT   = 2'b11;
   localparam logic [1:0] T_TAIL = 2'b10;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PAYLOAD = 2'd1, S_DROP = 2'd2} state_t;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt, r_len, w_len_nxt, w_cnt_inc;
   logic [3:0]  r_src, w_src_nxt;
   logic        r_pkt_err, w_err;
   logic [7:0]  r_drop_cnt;
   logic        w_drop_inc, w_decode;
   logic        w_push, w_push_last;
   logic [31:0] w_push_data;
   logic [36:0] r_mem [FIFO_DEPTH];
   logic [AW:0] r_wp, r_rp;
   logic        w_full, w_empty, w_pop, w_accept, w_head_ok;
   logic [1:0]  w_type;
   logic [31:0] w_data;

   assign w_type    = bus.flit_in[33:32];
   assign w_data    = bus.flit_in[31:0];
   assign w_head_ok = (w_data[31:28] == NODE_ID) && (w_data[7:0] != 8'd0) &&
                      (w_data[7:0] <= 8'(MAX_LEN));
   assign w_empty   = (r_wp == r_rp);
   assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_pop     = !w_empty && bus.NI_out_ready;
   assign w_accept  = bus.flit_valid && bus.flit_ready;
   assign w_cnt_inc = r_cnt + 8'd1;

   assign bus.flit_ready = (r_state == S_PAYLOAD) ? !w_full : 1'b1;
   assign o_dbg_state    = r_state;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_src_nxt   = r_src;
      w_err       = 1'b0;
      w_drop_inc  = 1'b0;
      w_decode    = 1'b0;
      w_push      = 1'b0;
      w_push_last = 1'b0;
      w_push_data = 32'h0;
      if (w_accept) begin
         case (r_state)
            S_IDLE: begin
               if (w_type[0]) w_decode = 1'b1;
               else           w_err    = 1'b1;
            end
            S_PAYLOAD: begin
               if (w_type[0]) begin
                  // A head interrupting a packet closes it with a zero word.
                  w_push      = 1'b1;
                  w_push_last = 1'b1;
                  w_err       = 1'b1;
                  w_decode    = 1'b1;
               end else begin
                  w_push      = 1'b1;
                  w_push_data = w_data;
                  w_cnt_nxt   = w_cnt_inc;
                  if (w_type == T_TAIL) begin
                     w_push_last = 1'b1;
                     w_err       = (w_cnt_inc != r_len);
                     w_state_nxt = S_IDLE;
                  end else if (w_cnt_inc == r_len) begin
                     w_push_last = 1'b1;
                     w_err       = 1'b1;
                     w_state_nxt = S_DROP;
                  end
               end
            end
            S_DROP: begin
               if (w_type[1]) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
         if (w_decode) begin
            if (w_type == T_HT) begin
               w_drop_inc  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_head_ok) begin
               w_src_nxt   = w_data[27:24];
               w_len_nxt   = w_data[7:0];
               w_cnt_nxt   = 8'd0;
               w_state_nxt = S_PAYLOAD;
            end else begin
               w_drop_inc  = 1'b1;
               w_state_nxt = S_DROP;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 8'd0;
         r_len      <= 8'd0;
         r_src      <= 4'd0;
         r_pkt_err  <= 1'b0;
         r_drop_cnt <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_len     <= w_len_nxt;
         r_src     <= w_src_nxt;
         r_pkt_err <= w_err;
         if (w_drop_inc && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   // Push is gated by full only; a same-cycle pop never frees a slot early.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp <= '0;
         r_rp <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push && !w_full) begin
            r_mem[r_wp[AW-1:0]] <= {w_push_last, r_src, w_push_data};
            r_wp                <= r_wp + {{AW{1'b0}}, 1'b1};
         end
         if (w_pop) r_rp <= r_rp + {{AW{1'b0}}, 1'b1};
      end
   end

   assign {bus.NI_out_last, bus.NI_out_src, bus.NI_out} = r_mem[r_rp[AW-1:0]];
   assign bus.NI_out_valid = !w_empty;
   assign bus.pkt_err      = r_pkt_err;
   assign bus.drop_cnt     = r_drop_cnt;
endmodule

// File: tb/tb_ni_rx_depacketizer.sv
// Directed bench for ni_rx_depacketizer with a packet-level reference model
// and a per-cycle compare process on NI_out and pkt_err.
module tb_ni_rx_depacketizer;
   localparam logic [3:0] NODE = 4'd0;
   localparam int         MAXL = 8;

   logic       clk, rst;
   logic [1:0] dbg_state;

   ni_rx_depacketizer_if bus();

   ni_rx_depacketizer #(.NODE_ID(NODE), .FIFO_DEPTH(4), .MAX_LEN(MAXL)) dut (
      .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_pass = 0, n_total = 0;
   int          cyc = 0, n_acc = 0, n_waits = 0, n_err_pulses = 0;
   bit          exp_err[int];
   logic [36:0] exp_q[$];
   logic [36:0] got_q[$];

   bit          m_in_pkt, m_discard;
   int          m_got, m_len, m_drops;
   logic [3:0]  m_src;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] hd(input logic [3:0] dest, input logic [3:0] src,
                                      input logic [7:0] len);
      return {dest, src, 16'h0, len};
   endfunction

   task automatic model_reset();
      m_in_pkt = 0; m_discard = 0; m_got = 0; m_len = 0; m_src = 4'd0; m_drops = 0;
      exp_q.delete();
      exp_err.delete();
   endtask

   task automatic model_drop();
      if (m_drops < 255) m_drops++;
   endtask

   task automatic model_head(input logic [31:0] d);
      if (d[31:28] == NODE && d[7:0] >= 1 && d[7:0] <= MAXL) begin
         m_in_pkt = 1; m_len = int'(d[7:0]); m_src = d[27:24]; m_got = 0;
      end else begin
         m_discard = 1;
         model_drop();
      end
   endtask

   // Packet-level rules: what each accepted flit means for the word stream.
   task automatic model_flit(input logic [1:0] t, input logic [31:0] d, output bit err);
      err = 0;
      if (m_discard) begin
         if (t[1]) m_discard = 0;
      end else if (!m_in_pkt) begin
         if (t == 2'b01)      model_head(d);
         else if (t == 2'b11) model_drop();
         else                 err = 1;
      end else if (t[0]) begin
         exp_q.push_back({1'b1, m_src, 32'h0});
         err = 1; m_in_pkt = 0;
         if (t == 2'b01) model_head(d);
         else            model_drop();
      end else begin
         m_got++;
         exp_q.push_back({(t == 2'b10) || (m_got == m_len), m_src, d});
         if (t == 2'b10) begin
            m_in_pkt = 0; err = (m_got != m_len);
         end else if (m_got == m_len) begin
            m_in_pkt = 0; m_discard = 1; err = 1;
         end
      end
   endtask

   always @(negedge clk) begin : cmp
      logic [36:0] a, w;
      bit          e;
      if (rst) begin
         e = exp_err.exists(cyc) ? exp_err[cyc] : 1'b0;
         if (exp_err.exists(cyc)) exp_err.delete(cyc);
         if (bus.pkt_err) n_err_pulses++;
         chk("pkt_err", {63'h0, bus.pkt_err}, {63'h0, e});
         if (bus.NI_out_valid && bus.NI_out_ready) begin
            a = {bus.NI_out_last, bus.NI_out_src, bus.NI_out};
            got_q.push_back(a);
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", a, $time);
            end else begin
               w = exp_q.pop_front();
               chk("ni_out_word", {27'h0, a}, {27'h0, w});
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the flit is taken.
   task automatic send_flit(input logic [1:0] t, input logic [31:0] d);
      int waits;
      bit err;
      bus.flit_in    = {t, d};
      bus.flit_valid = 1'b1;
      @(negedge clk);
      waits = 0;
      while (!bus.flit_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (waits > 0) n_waits++;
      if (!bus.flit_ready) begin
         n_total++;
         $display("FAIL flit_accept: flit_ready stayed 0, expected 1 within 200 cycles");
      end else begin
         model_flit(t, d, err);
         exp_err[cyc + 1] = err;
         n_acc++;
      end
      @(posedge clk); #1;
      bus.flit_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk(name, exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, w0, a0;
      rst = 1'b1;
      bus.flit_in = '0; bus.flit_valid = 1'b0; bus.NI_out_ready = 1'b1;
      model_reset();
      #3 rst = 1'b0;
      #1;
      chk("rst_valid", bus.NI_out_valid, 0);
      chk("rst_ni_out", bus.NI_out, 0);
      chk("rst_src", bus.NI_out_src, 0);
      chk("rst_last", bus.NI_out_last, 0);
      chk("rst_pkt_err", bus.pkt_err, 0);
      chk("rst_drop_cnt", bus.drop_cnt, 0);
      chk("rst_ready", bus.flit_ready, 1);
      chk("rst_state", dbg_state, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      // good two-word packet
      got_q.delete(); e0 = n_err_pulses;
      send_flit(2'b01, hd(NODE, 4'd3, 8'd2));
      send_flit(2'b00, 32'hAAAA0001);
      send_flit(2'b10, 32'hBBBB0002);
      drain("t1_drain");
      chk("t1_nwords", got_q.size(), 2);
      chk("t1_w0", got_q[0], {1'b0, 4'd3, 32'hAAAA0001});
      chk("t1_w1", got_q[1], {1'b1, 4'd3, 32'hBBBB0002});
      chk("t1_err", n_err_pulses - e0, 0);
      chk("t1_drop", bus.drop_cnt, 0);

      // misrouted packet
      got_q.delete(); w0 = n_waits;
      send_flit(2'b01, hd(4'd5, 4'd1, 8'd2));
      send_flit(2'b00, 32'h12345678);
      send_flit(2'b10, 32'h9ABCDEF0);
      drain("t2_drain");
      chk("t2_drop", bus.drop_cnt, 1);
      chk("t2_nwords", got_q.size(), 0);
      chk("t2_ready_waits", n_waits - w0, 0);

      // backpressure: 6 words into a 4-entry FIFO
      got_q.delete(); bus.NI_out_ready = 1'b0; a0 = n_acc;
      fork
         begin
            send_flit(2'b01, hd(NODE, 4'd2, 8'd6));
            for (int i = 1; i <= 5; i++) send_flit(2'b00, 32'hC0000000 + 32'(i));
            send_flit(2'b10, 32'hC0000006);
         end
         begin
            repeat (20) @(posedge clk);
            #1;
            chk("t3_ready_low", bus.flit_ready, 0);
            chk("t3_accepted", n_acc - a0, 5);
            chk("t3_head_word", {bus.NI_out_last, bus.NI_out_src, bus.NI_out},
                {1'b0, 4'd2, 32'hC0000001});
            bus.NI_out_ready = 1'b1;
         end
      join
      drain("t3_drain");
      chk("t3_nwords", got_q.size(), 6);
      chk("t3_w4", got_q[4], {1'b0, 4'd2, 32'hC0000005});
      chk("t3_w5", got_q[5], {1'b1, 4'd2, 32'hC0000006});

      // early tail
      got_q.delete(); e0 = n_err_pulses;
      send_flit(2'b01, hd(NODE, 4'd4, 8'd3));
      send_flit(2'b00, 32'h00000011);
      send_flit(2'b10, 32'h00000022);
      drain("t4_drain");
      chk("t4_w0", got_q[0], {1'b0, 4'd4, 32'h11});
      chk("t4_w1", got_q[1], {1'b1, 4'd4, 32'h22});
      chk("t4_err", n_err_pulses - e0, 1);

      // overlong packet: len=1 then body, tail
      got_q.delete(); e0 = n_err_pulses;
      send_flit(2'b01, hd(NODE, 4'd6, 8'd1));
      send_flit(2'b00, 32'h00000033);
      chk("t5_state_drop", dbg_state, 2);
      send_flit(2'b10, 32'h00000044);
      drain("t5_drain");
      chk("t5_nwords", got_q.size(), 1);
      chk("t5_w0", got_q[0], {1'b1, 4'd6, 32'h33});
      chk("t5_err", n_err_pulses - e0, 1);
      chk("t5_drop", bus.drop_cnt, 1);

      // head interrupting a packet
      got_q.delete(); e0 = n_err_pulses;
      send_flit(2'b01, hd(NODE, 4'd3, 8'd3));
      send_flit(2'b00, 32'h00000055);
      send_flit(2'b01, hd(NODE, 4'd5, 8'd2));
      send_flit(2'b00, 32'h00000066);
      send_flit(2'b10, 32'h00000077);
      drain("t6_drain");
      chk("t6_nwords", got_q.size(), 4);
      chk("t6_w1_close", got_q[1], {1'b1, 4'd3, 32'h0});
      chk("t6_w2", got_q[2], {1'b0, 4'd5, 32'h66});
      chk("t6_w3", got_q[3], {1'b1, 4'd5, 32'h77});
      chk("t6_err", n_err_pulses - e0, 1);

      // stray body in IDLE, head+tail flit, then drop saturation
      e0 = n_err_pulses; w0 = n_waits;
      send_flit(2'b00, 32'hDEAD0000);
      send_flit(2'b11, hd(NODE, 4'd1, 8'd1));
      repeat (2) @(posedge clk);
      #1;
      chk("t7_err", n_err_pulses - e0, 1);
      chk("t7_drop2", bus.drop_cnt, 2);
      for (int i = 0; i < 256; i++) begin
         send_flit(2'b01, hd(4'd9, 4'd1, 8'd2));
         send_flit(2'b00, 32'h1);
         send_flit(2'b10, 32'h2);
      end
      drain("t7_drain");
      chk("t7_drop_sat", bus.drop_cnt, 255);
      chk("t7_drop_model", bus.drop_cnt, m_drops);
      chk("t7_ready_waits", n_waits - w0, 0);

      // reset mid-packet with two buffered words
      bus.NI_out_ready = 1'b0;
      send_flit(2'b01, hd(NODE, 4'd7, 8'd4));
      send_flit(2'b00, 32'h00000088);
      send_flit(2'b00, 32'h00000099);
      chk("t8_valid_before", bus.NI_out_valid, 1);
      rst = 1'b0;
      #1;
      chk("t8_valid_rst", bus.NI_out_valid, 0);
      chk("t8_state_rst", dbg_state, 0);
      chk("t8_drop_rst", bus.drop_cnt, 0);
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      bus.NI_out_ready = 1'b1;
      got_q.delete();
      send_flit(2'b01, hd(NODE, 4'd8, 8'd1));
      send_flit(2'b10, 32'h000000AB);
      drain("t8_drain");
      chk("t8_nwords", got_q.size(), 1);
      chk("t8_w0", got_q[0], {1'b1, 4'd8, 32'hAB});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/ni_rx_depacketizer.md
Name: ni_rx_depacketizer

Overview:
- Receive side of the node network interface. Accepts flits from the local router port and checks the head flit. Reassembles payload words and buffers them in a small FIFO.
- Delivers payload words to the MIPS pipeline as NI_out, the return path for data sent from the execute stage on NI_in.
- Drops misrouted or malformed packets and reports them.

Parameters:
NODE_ID, 4'd0, this node's address; compared against the head-flit dest field.
FIFO_DEPTH, 4, number of output buffer entries (power of 2, ≥2).
MAX_LEN, 8, maximum payload words per packet.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
flit_in  input  34  [33:32] type (01 head, 00 body, 10 tail, 11 head+tail), [31:0] data.
flit_valid  input  1  router presents a flit.
flit_ready  output  1  flit accepted when flit_valid & flit_ready at the clock edge.
NI_out  output  32  payload word at the FIFO head.
NI_out_src  output  4  source node of that word.
NI_out_last  output  1  last word of the packet.
NI_out_valid  output  1  FIFO not empty.
NI_out_ready  input  1  pipeline consumes the word when valid & ready.
pkt_err  output  1  one-cycle registered pulse on any protocol or length error.
drop_cnt  output  8  count of dropped packets, saturating at 255.

Behaviour:
Reset and timing
- rst low asynchronously sets: state IDLE, FIFO empty, NI_out_valid 0, NI_out/NI_out_src/NI_out_last 0, pkt_err 0, drop_cnt 0, word counter 0, stored len/src 0.
- Reset mid-packet discards the partial packet and all buffered words.

Head flit fields
- [31:28] dest, [27:24] src, [7:0] len.
- A head is valid iff dest==NODE_ID and 1≤len≤MAX_LEN.

FSM states
- IDLE:
  - flit_ready=1.
  - Valid type-01 head: latch src and len, clear counter, go to PAYLOAD.
  - Invalid type-01 head: go to DROP, drop_cnt+1.
  - Type-11 flit: consumed, drop_cnt+1, stay in IDLE.
  - Body or tail flit: consumed and discarded, pkt_err pulse.
- PAYLOAD:
  - flit_ready = !fifo_full.
  - Body or tail flit: push {last=(type==10), src, data}, counter+1.
  - Tail: go to IDLE; if counter+1 != len, pulse pkt_err (word still delivered).
  - Body with counter+1 == len: push with last=1, pkt_err, go to DROP; no drop_cnt increment.
  - Head flit: push closing word {data=0, last=1}, pkt_err, then decode the new head exactly as in IDLE, all in the same cycle.
- DROP:
  - flit_ready=1; discard flits until a tail (type 10 or 11) is accepted, then go to IDLE.
  - A head seen in DROP is discarded.

FIFO
- Registered storage, FIFO_DEPTH entries, wrap-around read and write pointers with one extra bit for the full/empty distinction.
- Outputs are driven combinationally from the head entry.
- Latency: a word pushed at edge N is visible on NI_out with NI_out_valid=1 after edge N.
- When full, push is blocked even if a pop occurs in the same cycle (no bypass).
- Simultaneous push and pop when not full or empty: occupancy unchanged.
- NI_out_valid=0 when empty; NI_out holds its last value (don't-care).

Counters and errors
- drop_cnt saturates at 8'hFF.
- pkt_err registered, high exactly one cycle per error event; one pulse per cycle even if two causes coincide.

Test Plan:
- Head {dest=NODE_ID=0, src=3, len=2}, body 0xAAAA0001, tail 0xBBBB0002, NI_out_ready=1 → two words with src=3, last=0 then 1; pkt_err never high; drop_cnt=0.
- Head dest=5 (NODE_ID=0), body, tail → no NI_out_valid, drop_cnt=1, flit_ready high throughout; repeat 256 times → drop_cnt stays 255.
- len=6 packet with NI_out_ready=0 → flit_ready drops after 4 payload words; raise NI_out_ready → remaining 2 words accepted, order preserved, pointers wrap correctly.
- len=3 but tail after 1 body → 2 words delivered, last on the tail word, one pkt_err pulse; len=1 followed by body,tail → 1 word with last=1, pkt_err, tail discarded in DROP.
- Head mid-PAYLOAD → closing word data=0 last=1 pushed, pkt_err, new packet then delivered normally.
- Assert rst low mid-PAYLOAD with 2 buffered words → NI_out_valid=0 immediately, state IDLE, next valid packet received cleanly.
